// File: rtl/uart_tx_axis.sv
// AXI-Stream byte sink feeding a small FIFO and an 8N1 UART transmitter.
// ser_tx is registered from the current state, so the line lags the FSM by one cycle.
module uart_tx_axis #(
  parameter int unsigned CLKS_PER_BIT = 347,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          axis_clk,
  input  logic                          axis_rst_n,
  input  logic [7:0]                    ss_tdata,
  input  logic                          ss_tvalid,
  output logic                          ss_tready,
  output logic                          ser_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bitIdx_q, bitIdx_d;
  logic [7:0]      shift_q, shift_d;
  logic            serTx_q, serTx_d;
  logic            readyEn_q;
  logic [PW-1:0]   wrPtr_q, rdPtr_q;
  logic [LW-1:0]   level_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            push, pop, baudDone;

  // readyEn_q holds ss_tready low until the first edge after reset is released
  assign ss_tready  = readyEn_q && (level_q < LEVEL_FULL);
  assign push       = ss_tvalid && ss_tready;
  assign fifo_level = level_q;
  assign tx_busy    = (state_q != IDLE) || (level_q != '0);
  assign ser_tx     = serTx_q;
  assign baudDone   = (baud_q == BAUD_LAST);

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      readyEn_q <= 1'b0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      level_q   <= '0;
    end else begin
      readyEn_q <= 1'b1;
      if (push) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers and level define what is valid
  always_ff @(posedge axis_clk) begin
    if (push) mem_q[wrPtr_q] <= ss_tdata;
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      serTx_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      serTx_q  <= serTx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    serTx_d  = 1'b1;
    case (state_q)
      IDLE: begin
        baud_d   = '0;
        bitIdx_d = '0;
        if (level_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rdPtr_q];
          state_d = START;
        end
      end
      START: begin
        serTx_d = 1'b0;
        if (baudDone) begin
          baud_d   = '0;
          bitIdx_d = '0;
          state_d  = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        serTx_d = shift_q[0];
        if (baudDone) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baudDone) begin
          baud_d = '0;
          // Chain straight into the next start bit when more bytes are waiting
          if (level_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rdPtr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_axis.sv
// Scoreboard bench: a fast instance (4 clocks/bit) for the directed cases and a
// default-parameter instance for the baud-accurate random run.
module tb_uart_tx_axis;

  localparam int CPB_A = 4;
  localparam int CPB_B = 347;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] tdataCmd;
  logic       validCmd;
  logic       useB;
  logic       rxOn;
  logic       readyA, readyB, serA, serB, busyA, busyB;
  logic [2:0] levelA, levelB;

  wire validA = validCmd & ~useB;
  wire validB = validCmd & useB;
  wire selSer   = useB ? serB   : serA;
  wire selReady = useB ? readyB : readyA;
  wire selBusy  = useB ? busyB  : busyA;
  wire [2:0] selLevel = useB ? levelB : levelA;

  int checkCount = 0;
  int errorCount = 0;
  int cycleCnt = 0;
  int stallMinLevel, readyLevel, lastStall;
  logic [7:0] expQ[$];
  int startStamp[$];

  uart_tx_axis #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(4)) dutA (
    .axis_clk(clk), .axis_rst_n(rst_n), .ss_tdata(tdataCmd), .ss_tvalid(validA),
    .ss_tready(readyA), .ser_tx(serA), .tx_busy(busyA), .fifo_level(levelA)
  );

  uart_tx_axis dutB (
    .axis_clk(clk), .axis_rst_n(rst_n), .ss_tdata(tdataCmd), .ss_tvalid(validB),
    .ss_tready(readyB), .ser_tx(serB), .tx_busy(busyB), .fifo_level(levelB)
  );

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling clock edge; returns at the falling edge after acceptance
  task automatic applyStimulus(input logic [7:0] d);
    int guard = 0;
    tdataCmd = d;
    validCmd = 1'b1;
    while (selReady !== 1'b1 && guard < 20000) begin
      if (int'(selLevel) < stallMinLevel) stallMinLevel = int'(selLevel);
      @(negedge clk);
      guard++;
    end
    lastStall  = guard;
    readyLevel = int'(selLevel);
    if (selReady === 1'b1) expQ.push_back(d);
    else checkOutput("pushTimeout", guard, 0);
    @(negedge clk);
    validCmd = 1'b0;
  endtask

  task automatic waitDrain(input int limit);
    int guard = 0;
    while ((expQ.size() != 0 || selBusy !== 1'b0) && guard < limit) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drainQueue", expQ.size(), 0);
    checkOutput("drainIdle", selBusy, 0);
    repeat (4) @(negedge clk);
  endtask

  // Bench UART receiver: samples bit centres and requires every line edge on a bit boundary
  always begin : receiver
    int cpb, slot;
    logic [7:0] rxByte;
    logic prevLine;
    bit aborted;
    @(negedge clk);
    if (rxOn && selSer === 1'b0) begin
      cpb = useB ? CPB_B : CPB_A;
      startStamp.push_back(cycleCnt);
      prevLine = 1'b0;
      rxByte = '0;
      aborted = 1'b0;
      for (int n = 1; n <= 9 * cpb + cpb / 2; n++) begin
        @(negedge clk);
        if (!rxOn) begin
          aborted = 1'b1;
          break;
        end
        if (selSer !== prevLine) begin
          checkOutput("bitEdge", n % cpb, 0);
          prevLine = selSer;
        end
        if ((n - cpb / 2) % cpb == 0) begin
          slot = (n - cpb / 2) / cpb;
          if (slot == 0) checkOutput("startBit", selSer, 0);
          else if (slot <= 8) rxByte[slot-1] = selSer;
        end
      end
      if (!aborted) begin
        checkOutput("stopBit", selSer, 1);
        if (expQ.size() == 0) checkOutput("rxUnexpected", expQ.size(), 1);
        else checkOutput("rxData", rxByte, expQ.pop_front());
      end
    end
  end

  initial begin : watchdog
    repeat (95000) @(posedge clk);
    errorCount++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, base, falls;
    rst_n = 1'b0;
    tdataCmd = '0;
    validCmd = 1'b0;
    useB = 1'b0;
    rxOn = 1'b1;
    stallMinLevel = 99;
    repeat (3) @(negedge clk);
    checkOutput("rstSer", selSer, 1);
    checkOutput("rstReady", selReady, 0);
    checkOutput("rstBusy", selBusy, 0);
    checkOutput("rstLevel", selLevel, 0);
    rst_n = 1'b1;
    #1 checkOutput("readyBeforeEdge", selReady, 0);
    @(negedge clk);
    checkOutput("readyAfterEdge", selReady, 1);

    // Single byte: line falls two cycles after acceptance, busy spans pop plus a 10-bit frame
    applyStimulus(8'h41);
    checkOutput("lvlSingle", selLevel, 1);
    cyc = 0;
    while (selSer === 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    checkOutput("firstFall", cyc, 2);
    while (selBusy === 1'b1 && cyc < 1000) begin @(negedge clk); cyc++; end
    checkOutput("busyCycles", cyc, 1 + 10 * CPB_A);
    checkOutput("serIdle", selSer, 1);
    waitDrain(1000);

    // Back-to-back frames: the second start bit follows the first stop bit directly
    base = startStamp.size();
    applyStimulus(8'hAB);
    checkOutput("lvlB2b0", selLevel, 1);
    applyStimulus(8'h51);
    checkOutput("lvlB2b1", selLevel, 1);
    waitDrain(1000);
    checkOutput("lvlB2bEnd", selLevel, 0);
    checkOutput("b2bFrames", startStamp.size() - base, 2);
    if (startStamp.size() >= base + 2)
      checkOutput("b2bGap", startStamp[base+1] - startStamp[base], 10 * CPB_A);

    // Full FIFO: one byte in flight plus four queued, the sixth stalls until a pop
    for (int i = 0; i < 5; i++) applyStimulus(8'h10 + 8'(i));
    checkOutput("lvlFull", selLevel, 4);
    checkOutput("readyFull", selReady, 0);
    stallMinLevel = 99;
    applyStimulus(8'h6E);
    checkOutput("stalled", lastStall > 0, 1);
    checkOutput("lvlWhileStalled", stallMinLevel, 4);
    checkOutput("lvlAfterPop", readyLevel, 3);
    checkOutput("lvlRefill", selLevel, 4);
    waitDrain(2000);

    // Reset in the middle of data bit 3 with two bytes still queued
    applyStimulus(8'hFF);
    applyStimulus(8'hA5);
    applyStimulus(8'h3C);
    checkOutput("lvlQueued", selLevel, 2);
    repeat (17) @(negedge clk);
    rxOn = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstSer", selSer, 1);
    checkOutput("midRstLevel", selLevel, 0);
    checkOutput("midRstReady", selReady, 0);
    checkOutput("midRstBusy", selBusy, 0);
    expQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstLevel", selLevel, 0);
    checkOutput("postRstReady", selReady, 1);
    checkOutput("postRstBusy", selBusy, 0);
    rxOn = 1'b1;
    falls = 0;
    repeat (200) begin
      @(negedge clk);
      if (selSer !== 1'b1) falls++;
    end
    checkOutput("postRstQuiet", falls, 0);

    for (int i = 0; i < 256; i++) applyStimulus(8'($urandom_range(0, 255)));
    waitDrain(20000);

    // Default-parameter instance: exact 347-cycle bit time
    useB = 1'b1;
    @(negedge clk);
    checkOutput("bReady", selReady, 1);
    for (int i = 0; i < 12; i++) applyStimulus(8'($urandom_range(0, 255)));
    waitDrain(50000);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
